gpio_pad: RTL and testbench

GPIO_PAD -- requirements
Module: gpio_pad

---
 rtl/gpio_pad.sv | 105 ++++++++++
 tb/tb_gpio_pad.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad.sv
// GPIO pad block: per-pad mode decode, output/enable drive, synchronized and
// debounced inputs, and latched edge interrupts on debounced level changes.
module gpio_pad #(
  parameter int NUM_IO          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       reg_ctrl,
  input  logic [31:0]       reg_data,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic [NUM_IO-1:0] io_pin_o,
  input  logic [NUM_IO-1:0] irq_clr_i,
  output logic              irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] MODE_OUT = 2'b01;
  localparam logic [1:0] MODE_IN  = 2'b10;

  logic [NUM_IO-1:0] sync1_q, sync2_q;
  logic [NUM_IO-1:0] stable_q, stable_d;
  logic [NUM_IO-1:0] pend_q, pend_d;
  logic [NUM_IO-1:0] oe_q, oe_d;
  logic [NUM_IO-1:0] out_q, out_d;
  logic [CNT_W-1:0]  cnt_q [NUM_IO];
  logic [CNT_W-1:0]  cnt_d [NUM_IO];
  logic [1:0]        mode  [NUM_IO];

  // Control/data bits above the served pads are intentionally ignored.
  logic unused_reg_bits;
  assign unused_reg_bits = ^{reg_ctrl, reg_data};

  always_comb begin
    for (int i = 0; i < NUM_IO; i++) begin
      mode[i] = reg_ctrl[2*i +: 2];
    end
  end

  always_comb begin
    stable_d = stable_q;
    pend_d   = pend_q;
    oe_d     = '0;
    out_d    = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < NUM_IO; i++) begin
      oe_d[i]  = (mode[i] == MODE_OUT);
      out_d[i] = (mode[i] == MODE_OUT) & reg_data[i];

      // A new level is accepted on its DEBOUNCE_CYCLES-th consecutive sample.
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      // Set beats clear so a change coinciding with a clear is not lost.
      if ((stable_d[i] != stable_q[i]) && (mode[i] == MODE_IN)) begin
        pend_d[i] = 1'b1;
      end else if (irq_clr_i[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      oe_q     <= '0;
      out_q    <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= io_pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
      for (int i = 0; i < NUM_IO; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io_oe_o  = oe_q;
  assign io_out_o = out_q;
  assign io_pin_o = rst ? '0 : stable_q;
  assign irq_o    = ~rst & (|pend_q);

endmodule

// File: tb/tb_gpio_pad.sv
// Bench for gpio_pad: directed scenarios plus randomized traffic checked
// against a window-based behavioural model of synchronize/debounce/irq.
module tb_gpio_pad;
  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  reg_ctrl;
  logic [31:0]  reg_data;
  logic [N-1:0] io_pin_i;
  logic [N-1:0] io_out_o;
  logic [N-1:0] io_oe_o;
  logic [N-1:0] io_pin_o;
  logic [N-1:0] irq_clr_i;
  logic         irq_o;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [N-1:0] m_oe, m_out, m_stable, m_pend;
  logic [N-1:0] pin_q [$];
  logic [N-1:0] hist  [$];

  gpio_pad #(.NUM_IO(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_ctrl  (reg_ctrl),
    .reg_data  (reg_data),
    .io_pin_i  (io_pin_i),
    .io_out_o  (io_out_o),
    .io_oe_o   (io_oe_o),
    .io_pin_o  (io_pin_o),
    .irq_clr_i (irq_clr_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  // One rising edge; the model absorbs the inputs present at that edge.
  task automatic step();
    logic [N-1:0] sync_lvl;
    logic [N-1:0] new_stable;
    logic [1:0]   md;
    logic         all_diff;
    @(posedge clk);
    if (rst) begin
      m_oe = '0; m_out = '0; m_stable = '0; m_pend = '0;
      pin_q.delete(); pin_q.push_back('0); pin_q.push_back('0);
      hist.delete();
    end else begin
      // The level reaching the debouncer is the pad sampled two edges ago.
      sync_lvl = pin_q[pin_q.size()-2];
      hist.push_back(sync_lvl);
      if (hist.size() > D) void'(hist.pop_front());
      new_stable = m_stable;
      for (int i = 0; i < N; i++) begin
        if (hist.size() == D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) new_stable[i] = ~m_stable[i];
        end
      end
      for (int i = 0; i < N; i++) begin
        md = reg_ctrl[2*i +: 2];
        if (new_stable[i] != m_stable[i] && md == 2'b10) m_pend[i] = 1'b1;
        else if (irq_clr_i[i]) m_pend[i] = 1'b0;
        m_oe[i]  = (md == 2'b01);
        m_out[i] = (md == 2'b01) && reg_data[i];
      end
      m_stable = new_stable;
      pin_q.push_back(io_pin_i);
      if (pin_q.size() > 2) void'(pin_q.pop_front());
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_ctrl = 32'h5; reg_data = 32'h3; io_pin_i = '1; irq_clr_i = '0;
    steps(3);
    n_cmp++;
    if (io_oe_o !== 2'b00 || io_out_o !== 2'b00) begin
      n_err++; $display("FAIL reset_drive: oe=%b out=%b want 00/00", io_oe_o, io_out_o);
    end
    n_cmp++;
    if (io_pin_o !== 2'b00 || irq_o !== 1'b0) begin
      n_err++; $display("FAIL reset_inputs: pin=%b irq=%b want 00/0", io_pin_o, irq_o);
    end
    reg_ctrl = '0; reg_data = '0; io_pin_i = '0;
    rst = 1'b0;
    step();
    n_cmp++;
    if (io_pin_o !== 2'b00 || irq_o !== 1'b0) begin
      n_err++; $display("FAIL reset_release: pin=%b irq=%b want 00/0", io_pin_o, irq_o);
    end
    steps(4);
  endtask

  task automatic test_output_mode();
    logic [31:0] ctrl_tab [4] = '{32'h1, 32'h5, 32'h6, 32'hF};
    logic [1:0]  oe_tab   [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0]  out_tab  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    reg_data = 32'h1; reg_ctrl = 32'h1;
    step();
    n_cmp++;
    if (io_oe_o !== 2'b01 || io_out_o !== 2'b01) begin
      n_err++; $display("FAIL out_mode_on: oe=%b out=%b want 01/01", io_oe_o, io_out_o);
    end
    reg_ctrl = 32'h0;
    step();
    n_cmp++;
    if (io_oe_o !== 2'b00 || io_out_o !== 2'b00) begin
      n_err++; $display("FAIL out_mode_off: oe=%b out=%b want 00/00", io_oe_o, io_out_o);
    end
    reg_data = 32'h3;
    for (int k = 0; k < 4; k++) begin
      reg_ctrl = ctrl_tab[k];
      step();
      n_cmp++;
      if (io_oe_o !== oe_tab[k] || io_out_o !== out_tab[k]) begin
        n_err++; $display("FAIL out_mode_tab%0d: oe=%b out=%b want %b/%b", k, io_oe_o, io_out_o, oe_tab[k], out_tab[k]);
      end
    end
    reg_ctrl = 32'h5; reg_data = 32'h2;
    step();
    n_cmp++;
    if (io_out_o !== 2'b10) begin
      n_err++; $display("FAIL out_data: out=%b want 10", io_out_o);
    end
    reg_ctrl = 32'h0; reg_data = 32'h0;
    step();
  endtask

  // Also covers a clear arriving on the same edge the level falls.
  task automatic test_debounce_latency();
    reg_ctrl = 32'h2; io_pin_i = 2'b00;
    steps(8);
    io_pin_i[0] = 1'b1;
    steps(5);
    n_cmp++;
    if (io_pin_o[0] !== 1'b0 || irq_o !== 1'b0) begin
      n_err++; $display("FAIL rise_edge5: pin0=%b irq=%b want 0/0", io_pin_o[0], irq_o);
    end
    step();
    n_cmp++;
    if (io_pin_o[0] !== 1'b1 || irq_o !== 1'b1) begin
      n_err++; $display("FAIL rise_edge6: pin0=%b irq=%b want 1/1", io_pin_o[0], irq_o);
    end
    irq_clr_i = 2'b01;
    step();
    irq_clr_i = 2'b00;
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_err++; $display("FAIL irq_clear: irq=%b want 0", irq_o);
    end
    io_pin_i[0] = 1'b0;
    steps(5);
    irq_clr_i = 2'b01;
    step();
    n_cmp++;
    if (io_pin_o[0] !== 1'b0 || irq_o !== 1'b1) begin
      n_err++; $display("FAIL set_beats_clear: pin0=%b irq=%b want 0/1", io_pin_o[0], irq_o);
    end
    step();
    irq_clr_i = 2'b00;
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_err++; $display("FAIL clear_after_set: irq=%b want 0", irq_o);
    end
  endtask

  task automatic test_glitch();
    reg_ctrl = 32'h2; io_pin_i = 2'b00;
    steps(8);
    for (int k = 0; k < 12; k++) begin
      io_pin_i[0] = (k < 3);
      step();
      n_cmp++;
      if (io_pin_o[0] !== 1'b0 || irq_o !== 1'b0) begin
        n_err++; $display("FAIL glitch_c%0d: pin0=%b irq=%b want 0/0", k, io_pin_o[0], irq_o);
      end
    end
  endtask

  task automatic test_hiz_input();
    reg_ctrl = 32'h0; io_pin_i = 2'b00;
    steps(8);
    io_pin_i[1] = 1'b1;
    steps(5);
    n_cmp++;
    if (io_pin_o[1] !== 1'b0) begin
      n_err++; $display("FAIL hiz_edge5: pin1=%b want 0", io_pin_o[1]);
    end
    step();
    n_cmp++;
    if (io_pin_o[1] !== 1'b1 || irq_o !== 1'b0 || io_oe_o !== 2'b00) begin
      n_err++; $display("FAIL hiz_edge6: pin1=%b irq=%b oe=%b want 1/0/00", io_pin_o[1], irq_o, io_oe_o);
    end
    io_pin_i[1] = 1'b0;
    steps(6);
    n_cmp++;
    if (io_pin_o[1] !== 1'b0 || irq_o !== 1'b0) begin
      n_err++; $display("FAIL hiz_fall: pin1=%b irq=%b want 0/0", io_pin_o[1], irq_o);
    end
  endtask

  task automatic test_reset_mid_count();
    reg_ctrl = 32'h2; io_pin_i = 2'b00;
    steps(8);
    io_pin_i[0] = 1'b1;
    steps(3);
    rst = 1'b1;
    step();
    n_cmp++;
    if (io_pin_o[0] !== 1'b0 || irq_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_hold: pin0=%b irq=%b want 0/0", io_pin_o[0], irq_o);
    end
    rst = 1'b0;
    steps(5);
    n_cmp++;
    if (io_pin_o[0] !== 1'b0) begin
      n_err++; $display("FAIL midrst_edge5: pin0=%b want 0", io_pin_o[0]);
    end
    step();
    n_cmp++;
    if (io_pin_o[0] !== 1'b1 || irq_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_edge6: pin0=%b irq=%b want 1/1", io_pin_o[0], irq_o);
    end
    irq_clr_i = 2'b11;
    step();
    irq_clr_i = 2'b00;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_pin;
    logic         exp_irq;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) reg_ctrl = $urandom;
      if ($urandom_range(0, 9) == 0) reg_data = $urandom;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) io_pin_i[i] = ~io_pin_i[i];
        irq_clr_i[i] = ($urandom_range(0, 7) == 0);
      end
      step();
      exp_pin = rst ? '0 : m_stable;
      exp_irq = rst ? 1'b0 : (|m_pend);
      n_cmp++;
      if (io_oe_o !== m_oe || io_out_o !== m_out) begin
        n_err++; $display("FAIL rand_drive c%0d: oe=%b out=%b want %b/%b", c, io_oe_o, io_out_o, m_oe, m_out);
      end
      n_cmp++;
      if (io_pin_o !== exp_pin) begin
        n_err++; $display("FAIL rand_pin c%0d: pin=%b want %b", c, io_pin_o, exp_pin);
      end
      n_cmp++;
      if (irq_o !== exp_irq) begin
        n_err++; $display("FAIL rand_irq c%0d: irq=%b want %b", c, irq_o, exp_irq);
      end
    end
    rst = 1'b0; irq_clr_i = '0;
  endtask

  initial begin
    m_oe = '0; m_out = '0; m_stable = '0; m_pend = '0;
    pin_q.push_back('0); pin_q.push_back('0);
    test_reset();
    test_output_mode();
    test_debounce_latency();
    test_glitch();
    test_hiz_input();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
